rr_bus_arbiter: RTL
===================

Name: rr_bus_arbiter

Overview:
- Round-robin N:1 arbiter for the shared valid/resp memory bus: cores, DMA and debug ports share one memory/peripheral master port.
- Unlike a fixed-priority pass-through, the winning request is captured into registers, so the master side is fully registered.
- A per-transaction timeout aborts hung transactions and returns an error to the owning port.
- Sits between requester ports and the memory/interconnect master port.

Parameters:
- NPORTS, 2, number of requester (slave) ports, >=1
- ADDRW, 32, address width
- DATAW, 32, data width
- MASKW, DATAW/8, byte-mask width
- TIMEOUT, 0, cycles master_valid_o may stay high without master_resp_i before abort; 0 disables the timeout
- Derived: GRANTW = (NPORTS>1) ? $clog2(NPORTS) : 1; TOW = $clog2(TIMEOUT+1) (minimum 1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slave_addr_i  in  NPORTS*ADDRW  bundled addresses, port i at [i*ADDRW +: ADDRW]
- slave_rdata_o  out  NPORTS*DATAW  read data, broadcast to all ports
- slave_wdata_i  in  NPORTS*DATAW  bundled write data
- slave_mask_i  in  NPORTS*MASKW  bundled byte masks
- slave_we_i  in  NPORTS  write enables
- slave_valid_i  in  NPORTS  request valid, held high until that port's resp
- slave_resp_o  out  NPORTS  one-cycle completion pulse per port
- slave_err_o  out  NPORTS  qualifies slave_resp_o: 1 = aborted by timeout
- master_addr_o  out  ADDRW  registered address
- master_rdata_i  in  DATAW  read data
- master_wdata_o  out  DATAW  registered write data
- master_mask_o  out  MASKW  registered mask
- master_we_o  out  1  registered write enable
- master_valid_o  out  1  request valid
- master_resp_i  in  1  completion pulse
- busy_o  out  1  transaction outstanding
- grant_o  out  GRANTW  index of current or last owner

Behaviour:
- Reset (synchronous, rst_i high at posedge):
  - state=IDLE; all master_* outputs 0; busy_o=0.
  - last_grant = NPORTS-1, so port 0 has first priority; grant_o = NPORTS-1.
  - Timeout counter = 0.
  - Reset mid-transaction drops the transaction silently: no slave_resp_o is generated.
- State IDLE:
  - master_valid_o=0.
  - If any slave_valid_i is high, select the first requester scanning (last_grant+1) .. wrapping mod NPORTS.
  - At the clock edge: latch that port's addr/wdata/mask/we into master_* registers, set grant_o, go BUSY.
- State BUSY:
  - master_valid_o=1, busy_o=1; master_* outputs are stable for the whole state.
  - Request latency: slave_valid_i rises in cycle N -> master_valid_o high in cycle N+1.
- Completion (BUSY and master_resp_i=1):
  - Same cycle, combinationally: slave_resp_o[grant_o]=1, slave_err_o=0, slave_rdata_o = {NPORTS{master_rdata_i}}.
  - Next edge: last_grant <= grant_o, counter cleared, go IDLE.
- Minimum spacing: one IDLE cycle between transactions. Back-to-back throughput is one transaction per 2 cycles plus master latency.
- Timeout (TIMEOUT>0):
  - The counter increments every BUSY cycle without master_resp_i.
  - When counter == TIMEOUT-1 and master_resp_i=0 in that cycle: slave_resp_o[grant_o]=1, slave_err_o[grant_o]=1, slave_rdata_o=0.
  - Next edge: master_valid_o drops, last_grant updated, go IDLE.
  - master_resp_i arriving in that same cycle takes precedence: normal completion, no error.
- Port isolation: slave_resp_o/slave_err_o are zero for all non-granted ports and everywhere outside completion/abort cycles.
- Ignored inputs:
  - master_resp_i while IDLE.
  - A granted port dropping slave_valid_i mid-transaction (protocol violation); the transaction still completes and resp is still pulsed to that port.
- Fairness: with all ports requesting continuously, grants rotate 0,1,..,NPORTS-1,0. No port waits more than NPORTS-1 transactions.
- NPORTS=1: degenerates to a registered pass-through with timeout; grant_o is always 0.
- No combinational path from slave_*_i to master_*_o. rdata/resp paths from master to slave are combinational.

Test Plan:
- Reset/idle: NPORTS=3, assert rst_i 2 cycles, no requests -> all master_* outputs 0, busy_o=0, grant_o=2, slave_resp_o=0.
- Single read: port1 valid, addr=0x1000, we=0 at cycle N -> master_valid_o=1 with addr=0x1000 at N+1; master_resp_i at N+3 with rdata=0xDEADBEEF -> slave_resp_o=3'b010 and slave_rdata_o[63:32]=0xDEADBEEF in N+3; master_valid_o=0 at N+4.
- Round-robin: all 3 ports request continuously, master responds 1 cycle after valid -> grant order 0,1,2,0,1,2; each port gets exactly 2 resp pulses in 6 transactions.
- Write capture: port2 wdata=0xA5A5A5A5, mask=4'b0011, we=1; port2 changes wdata to 0 while BUSY -> master_wdata_o stays 0xA5A5A5A5 until resp.
- Timeout: TIMEOUT=16, port0 request, master never responds -> master_valid_o high exactly 16 cycles; slave_resp_o[0]=1 and slave_err_o[0]=1 in the 16th cycle; IDLE next; a pending port1 request is granted after.
- Reset mid-transaction: rst_i asserted while BUSY -> next cycle master_valid_o=0, no slave_resp_o pulse, grant_o=2; a new request proceeds normally afterwards.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin N:1 arbiter for the valid/resp memory bus. The winning request is
// captured into registers so the master side is fully registered; an optional timeout aborts hung transactions.
module rr_bus_arbiter #(
    parameter int NPORTS  = 2,
    parameter int ADDRW   = 32,
    parameter int DATAW   = 32,
    parameter int MASKW   = DATAW / 8,
    parameter int TIMEOUT = 0,
    localparam int GRANTW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NPORTS*ADDRW-1:0]  slave_addr_i,
    output logic [NPORTS*DATAW-1:0]  slave_rdata_o,
    input  logic [NPORTS*DATAW-1:0]  slave_wdata_i,
    input  logic [NPORTS*MASKW-1:0]  slave_mask_i,
    input  logic [NPORTS-1:0]        slave_we_i,
    input  logic [NPORTS-1:0]        slave_valid_i,
    output logic [NPORTS-1:0]        slave_resp_o,
    output logic [NPORTS-1:0]        slave_err_o,
    output logic [ADDRW-1:0]         master_addr_o,
    input  logic [DATAW-1:0]         master_rdata_i,
    output logic [DATAW-1:0]         master_wdata_o,
    output logic [MASKW-1:0]         master_mask_o,
    output logic                     master_we_o,
    output logic                     master_valid_o,
    input  logic                     master_resp_i,
    output logic                     busy_o,
    output logic [GRANTW-1:0]        grant_o
);

    localparam int TOW_RAW = $clog2(TIMEOUT + 1);
    localparam int TOW     = (TOW_RAW < 1) ? 1 : TOW_RAW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_reg;
    logic [GRANTW-1:0] grant_reg;
    logic [ADDRW-1:0]  addr_reg;
    logic [DATAW-1:0]  wdata_reg;
    logic [MASKW-1:0]  mask_reg;
    logic              we_reg;
    logic [TOW-1:0]    to_cnt_reg;

    logic [ADDRW-1:0]  addr_arr  [NPORTS];
    logic [DATAW-1:0]  wdata_arr [NPORTS];
    logic [MASKW-1:0]  mask_arr  [NPORTS];

    logic              busy;
    logic              done;
    logic              abort;
    logic              fin;
    logic              sel_found;
    logic [GRANTW-1:0] sel_idx;
    logic [GRANTW:0]   cand;

    assign busy  = (state_reg == ST_BUSY);
    assign done  = busy && master_resp_i;
    // A response in the final timeout cycle wins over the abort.
    assign abort = (TIMEOUT != 0) && busy && !master_resp_i
                   && (to_cnt_reg == TOW'(TIMEOUT - 1));
    assign fin   = done || abort;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign addr_arr[gi]  = slave_addr_i[gi*ADDRW +: ADDRW];
            assign wdata_arr[gi] = slave_wdata_i[gi*DATAW +: DATAW];
            assign mask_arr[gi]  = slave_mask_i[gi*MASKW +: MASKW];
            assign slave_resp_o[gi] = fin && (grant_reg == GRANTW'(gi));
            assign slave_err_o[gi]  = abort && (grant_reg == GRANTW'(gi));
            assign slave_rdata_o[gi*DATAW +: DATAW] = abort ? '0 : master_rdata_i;
        end
    endgenerate

    // Scan from the port after the last owner; iterating backwards lets the
    // nearest requester overwrite farther ones.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            cand = {1'b0, grant_reg} + (GRANTW+1)'(k);
            if (cand >= (GRANTW+1)'(NPORTS)) begin
                cand = cand - (GRANTW+1)'(NPORTS);
            end
            if (slave_valid_i[cand[GRANTW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GRANTW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= GRANTW'(NPORTS - 1);
            addr_reg   <= '0;
            wdata_reg  <= '0;
            mask_reg   <= '0;
            we_reg     <= 1'b0;
            to_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    to_cnt_reg <= '0;
                    if (sel_found) begin
                        addr_reg  <= addr_arr[sel_idx];
                        wdata_reg <= wdata_arr[sel_idx];
                        mask_reg  <= mask_arr[sel_idx];
                        we_reg    <= slave_we_i[sel_idx];
                        grant_reg <= sel_idx;
                        state_reg <= ST_BUSY;
                    end
                end
                default: begin
                    if (fin) begin
                        to_cnt_reg <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign master_addr_o  = addr_reg;
    assign master_wdata_o = wdata_reg;
    assign master_mask_o  = mask_reg;
    assign master_we_o    = we_reg;
    assign master_valid_o = busy;
    assign busy_o         = busy;
    assign grant_o        = grant_reg;

endmodule
